// File: rtl/decode_pkg.sv
// decode_pkg: shared RV32IM decode encodings, control bundle and immediate helpers
package decode_pkg;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SHIFT = 4'd7,
                         ALU_PASSB = 4'd8, ALU_EQ = 4'd9, ALU_NE = 4'd10, ALU_GE = 4'd11,
                         ALU_GEU = 4'd12;
  localparam logic [2:0] MUL_NONE = 3'd0, MUL_MUL = 3'd1, MUL_MULH = 3'd2, MUL_MULHSU = 3'd3,
                         MUL_MULHU = 3'd4;
  localparam logic [2:0] DIV_NONE = 3'd0, DIV_DIV = 3'd1, DIV_DIVU = 3'd2, DIV_REM = 3'd3,
                         DIV_REMU = 3'd4;
  localparam logic [1:0] SH_NONE = 2'd0, SH_SLL = 2'd1, SH_SRL = 2'd2, SH_SRA = 2'd3;
  localparam logic [2:0] IMM_NONE = 3'd0, IMM_I = 3'd1, IMM_S = 3'd2, IMM_B = 3'd3,
                         IMM_U = 3'd4, IMM_J = 3'd5, IMM_SH = 3'd6;
  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
                         OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011,
                         OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP = 7'b0110011,
                         OPC_FENCE = 7'b0001111, OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic [2:0]  mul_op;
    logic [2:0]  div_op;
    logic [1:0]  shift_op;
    logic        alu_src_a;
    logic        alu_src_b;
    logic [1:0]  alu_bytes;
    logic        mem_re;
    logic        mem_we;
    logic        mem_to_reg;
    logic        branch_en;
    logic        jal_en;
    logic        jalr_en;
    logic        unsigned_flag;
    logic        reg_we;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } decode_ctrl_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] i, input logic [2:0] t);
    return t == IMM_I  ? {{20{i[31]}}, i[31:20]} :
           t == IMM_S  ? {{20{i[31]}}, i[31:25], i[11:7]} :
           t == IMM_B  ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
           t == IMM_U  ? {i[31:12], 12'h0} :
           t == IMM_J  ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} :
           t == IMM_SH ? {27'd0, i[24:20]} : 32'd0;
  endfunction

  // funct3 -> ALU op shared by OP and OP-IMM (SUB is resolved by the caller)
  function automatic logic [3:0] alu_f3(input logic [2:0] f3);
    return f3 == 3'b000 ? ALU_ADD : f3 == 3'b010 ? ALU_SLT : f3 == 3'b011 ? ALU_SLTU :
           f3 == 3'b100 ? ALU_XOR : f3 == 3'b110 ? ALU_OR : f3 == 3'b111 ? ALU_AND : ALU_SHIFT;
  endfunction
endpackage

// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch-side and execute-side handshakes of the decode queue
interface decode_queue_if import decode_pkg::*; #(parameter int ILL_CNT_W = 16) ();
  logic                 in_valid, in_ready, flush;
  logic [31:0]          in_insn, in_pc;
  logic                 out_valid, out_ready, out_illegal;
  logic [31:0]          out_pc, out_insn;
  decode_ctrl_t         out_ctrl;
  logic [ILL_CNT_W-1:0] ill_count;
  modport master (output in_valid, in_insn, in_pc, flush, out_ready,
                  input in_ready, out_valid, out_pc, out_insn, out_ctrl, out_illegal, ill_count);
  modport slave (input in_valid, in_insn, in_pc, flush, out_ready,
                 output in_ready, out_valid, out_pc, out_insn, out_ctrl, out_illegal, ill_count);
endinterface

// File: rtl/decode_queue_insn_decoder.sv
// insn_decoder: combinational RV32IM instruction word to control bundle plus illegal flag
module insn_decoder import decode_pkg::*; #(
  parameter bit ENABLE_MUL = 1'b1,
  parameter bit ENABLE_DIV = 1'b1
) (
  input  logic [31:0]  insn,
  output decode_ctrl_t ctrl,
  output logic         illegal
);
  logic [6:0] op, f7;
  logic [2:0] f3, it;
  logic [1:0] sh;
  logic       ill;
  decode_ctrl_t c;
  assign op = insn[6:0];
  assign f3 = insn[14:12];
  assign f7 = insn[31:25];
  assign sh = f3 == 3'b001 ? SH_SLL : f3 == 3'b101 ? (f7[5] ? SH_SRA : SH_SRL) : SH_NONE;
  always_comb begin
    c = '0;
    ill = 1'b0;
    it = IMM_NONE;
    case (op)
      OPC_LUI: begin
        it = IMM_U; c.alu_op = ALU_PASSB; c.alu_src_b = 1'b1; c.reg_we = 1'b1;
      end
      OPC_AUIPC: begin
        it = IMM_U; c.alu_src_a = 1'b1; c.alu_src_b = 1'b1; c.reg_we = 1'b1;
      end
      OPC_JAL: begin
        it = IMM_J; c.alu_src_a = 1'b1; c.alu_src_b = 1'b1; c.jal_en = 1'b1; c.reg_we = 1'b1;
      end
      OPC_JALR: begin
        it = IMM_I; c.alu_src_b = 1'b1; c.jalr_en = 1'b1; c.reg_we = 1'b1; ill = f3 != 3'b000;
      end
      OPC_BRANCH: begin
        it = IMM_B;
        c.branch_en = 1'b1;
        c.unsigned_flag = f3[2] & f3[1];
        c.alu_op = f3 == 3'b000 ? ALU_EQ : f3 == 3'b001 ? ALU_NE : f3 == 3'b100 ? ALU_SLT :
                   f3 == 3'b101 ? ALU_GE : f3 == 3'b110 ? ALU_SLTU : ALU_GEU;
        ill = f3[2:1] == 2'b01;
      end
      OPC_LOAD: begin
        it = IMM_I; c.alu_src_b = 1'b1; c.mem_re = 1'b1; c.mem_to_reg = 1'b1; c.reg_we = 1'b1;
        c.alu_bytes = f3[1:0];
        c.unsigned_flag = f3[2];
        ill = f3[1:0] == 2'b11 || f3 == 3'b110;
      end
      OPC_STORE: begin
        it = IMM_S; c.alu_src_b = 1'b1; c.mem_we = 1'b1; c.alu_bytes = f3[1:0];
        ill = f3[2] || f3[1:0] == 2'b11;
      end
      OPC_OPIMM: begin
        it = f3[1:0] == 2'b01 ? IMM_SH : IMM_I;
        c.alu_src_b = 1'b1; c.reg_we = 1'b1;
        c.alu_op = alu_f3(f3);
        c.unsigned_flag = f3 == 3'b011;
        c.shift_op = sh;
        // shamt[5] (insn[25]) set is an RV64 encoding and falls out here as a bad funct7
        ill = (f3 == 3'b001 && f7 != 7'd0) || (f3 == 3'b101 && f7 != 7'd0 && f7 != 7'b0100000);
      end
      OPC_OP: begin
        c.reg_we = 1'b1;
        if (f7 == 7'b0000001) begin
          c.mul_op = f3[2] ? MUL_NONE : {1'b0, f3[1:0]} + 3'd1;
          c.div_op = f3[2] ? {1'b0, f3[1:0]} + 3'd1 : DIV_NONE;
          c.unsigned_flag = f3[2] & f3[0];
          ill = f3[2] ? !ENABLE_DIV : !ENABLE_MUL;
        end else begin
          c.alu_op = (f7[5] && f3 == 3'b000) ? ALU_SUB : alu_f3(f3);
          c.unsigned_flag = f3 == 3'b011;
          c.shift_op = sh;
          ill = f7 != 7'd0 && !(f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
        end
      end
      OPC_FENCE: ill = f3 != 3'b000;
      OPC_SYSTEM: ill = insn[31:21] != 11'd0 || insn[19:7] != 13'd0;
      default: ill = 1'b1;
    endcase
    c.imm = gen_imm(insn, it);
    c.rs1 = it == IMM_U ? 5'd0 : insn[19:15];
    c.rs2 = (op == OPC_OP || op == OPC_STORE || op == OPC_BRANCH) ? insn[24:20] : 5'd0;
    c.reg_we = c.reg_we & (insn[11:7] != 5'd0);
    c.rd = c.reg_we ? insn[11:7] : 5'd0;
  end
  assign illegal = ill;
  assign ctrl = ill ? '0 : c;
endmodule

// File: rtl/decode_queue.sv
// decode_queue: decode-at-enqueue FIFO between fetch and execute with flush and illegal counting
module decode_queue import decode_pkg::*; #(
  parameter int DEPTH      = 2,
  parameter bit ENABLE_MUL = 1'b1,
  parameter bit ENABLE_DIV = 1'b1,
  parameter int ILL_CNT_W  = 16
) (
  input logic          clk,
  input logic          reset,
  decode_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [31:0]  pc;
    logic [31:0]  insn;
    decode_ctrl_t ctrl;
    logic         illegal;
  } entry_t;
  entry_t               mem [DEPTH];
  entry_t               head;
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic [ILL_CNT_W-1:0] ill_cnt;
  decode_ctrl_t         dec_ctrl;
  logic                 dec_ill, enq, deq;
  insn_decoder #(.ENABLE_MUL(ENABLE_MUL), .ENABLE_DIV(ENABLE_DIV)) u_dec (
    .insn(bus.in_insn), .ctrl(dec_ctrl), .illegal(dec_ill)
  );
  // ready depends only on stored occupancy, so a full queue refuses even when draining
  assign bus.in_ready = ~reset & (count != (AW+1)'(DEPTH));
  assign bus.out_valid = count != '0;
  assign enq = bus.in_valid & bus.in_ready & ~bus.flush;
  assign deq = bus.out_valid & bus.out_ready & ~bus.flush;
  assign head = bus.out_valid ? mem[rd_ptr] : '0;
  assign bus.out_pc = head.pc;
  assign bus.out_insn = head.insn;
  assign bus.out_ctrl = head.ctrl;
  assign bus.out_illegal = head.illegal;
  assign bus.ill_count = ill_cnt;
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(enq);
      rd_ptr <= rd_ptr + AW'(deq);
      count <= count + (AW+1)'(enq) - (AW+1)'(deq);
    end
    if (reset) ill_cnt <= '0;
    else if (enq && dec_ill && !(&ill_cnt)) ill_cnt <= ill_cnt + ILL_CNT_W'(1);
    if (enq) mem[wr_ptr] <= entry_t'{bus.in_pc, bus.in_insn, dec_ctrl, dec_ill};
  end
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed scenario tasks for decode_queue with hand-computed expectations
module tb_decode_queue;
  import decode_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n = 0;
  int errs = 0;
  decode_queue_if #(.ILL_CNT_W(4)) b0 ();
  decode_queue_if #(.ILL_CNT_W(16)) b1 ();
  decode_queue #(.DEPTH(2), .ENABLE_MUL(1'b1), .ENABLE_DIV(1'b1), .ILL_CNT_W(4)) dut (
    .clk(clk), .reset(reset), .bus(b0)
  );
  decode_queue #(.DEPTH(2), .ENABLE_MUL(1'b1), .ENABLE_DIV(1'b0), .ILL_CNT_W(16)) dut_nodiv (
    .clk(clk), .reset(reset), .bus(b1)
  );
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] insn, input logic [31:0] pc);
    b0.in_valid = v;
    b0.in_insn = insn;
    b0.in_pc = pc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 32'hFFFFFFFF, 32'h0);
    b0.flush = 1'b1;
    b0.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.in_insn = '0; b1.in_pc = '0; b1.flush = 1'b0; b1.out_ready = 1'b1;
    step();
    step();
    n++; if (b0.in_ready !== 1'b0) begin errs++; $display("FAIL rst_in_ready: got %0h expected 0", b0.in_ready); end
    n++; if (b0.out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid: got %0h expected 0", b0.out_valid); end
    n++; if (b0.ill_count !== 4'd0) begin errs++; $display("FAIL rst_ill_count: got %0h expected 0", b0.ill_count); end
    reset = 1'b0;
    b0.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #1;
    n++; if (b0.in_ready !== 1'b1) begin errs++; $display("FAIL rel_in_ready: got %0h expected 1", b0.in_ready); end
    n++; if (b0.out_ctrl !== '0) begin errs++; $display("FAIL rel_ctrl_zero: got %0h expected 0", b0.out_ctrl); end
    n++; if (b0.out_pc !== 32'h0) begin errs++; $display("FAIL rel_pc_zero: got %0h expected 0", b0.out_pc); end
  endtask

  task automatic test_addi();
    b0.out_ready = 1'b0;
    drive(1'b1, 32'h00500093, 32'h100);
    step();
    drive(1'b0, 32'h0, 32'h0);
    n++; if (b0.out_valid !== 1'b1) begin errs++; $display("FAIL addi_valid: got %0h expected 1", b0.out_valid); end
    n++; if (b0.out_pc !== 32'h100) begin errs++; $display("FAIL addi_pc: got %0h expected 100", b0.out_pc); end
    n++; if (b0.out_ctrl.imm !== 32'd5) begin errs++; $display("FAIL addi_imm: got %0h expected 5", b0.out_ctrl.imm); end
    n++; if (b0.out_ctrl.alu_src_b !== 1'b1) begin errs++; $display("FAIL addi_src_b: got %0h expected 1", b0.out_ctrl.alu_src_b); end
    n++; if (b0.out_ctrl.reg_we !== 1'b1) begin errs++; $display("FAIL addi_reg_we: got %0h expected 1", b0.out_ctrl.reg_we); end
    n++; if (b0.out_ctrl.rd !== 5'd1) begin errs++; $display("FAIL addi_rd: got %0h expected 1", b0.out_ctrl.rd); end
    n++; if (b0.out_ctrl.rs1 !== 5'd0) begin errs++; $display("FAIL addi_rs1: got %0h expected 0", b0.out_ctrl.rs1); end
    n++; if (b0.out_ctrl.alu_op !== ALU_ADD) begin errs++; $display("FAIL addi_alu_op: got %0h expected %0h", b0.out_ctrl.alu_op, ALU_ADD); end
    b0.out_ready = 1'b1;
    step();
    n++; if (b0.out_valid !== 1'b0) begin errs++; $display("FAIL addi_drained: got %0h expected 0", b0.out_valid); end
    n++; if (b0.out_insn !== 32'h0) begin errs++; $display("FAIL empty_insn_zero: got %0h expected 0", b0.out_insn); end
  endtask

  task automatic test_full_drain();
    b0.out_ready = 1'b0;
    drive(1'b1, 32'h00100113, 32'h200);
    step();
    drive(1'b1, 32'h00100113, 32'h204);
    step();
    n++; if (b0.in_ready !== 1'b0) begin errs++; $display("FAIL full_in_ready: got %0h expected 0", b0.in_ready); end
    n++; if (b0.out_pc !== 32'h200) begin errs++; $display("FAIL full_head_pc: got %0h expected 200", b0.out_pc); end
    drive(1'b1, 32'h00100113, 32'h208);
    b0.out_ready = 1'b1;
    step();
    n++; if (b0.in_ready !== 1'b1) begin errs++; $display("FAIL deq_in_ready: got %0h expected 1", b0.in_ready); end
    n++; if (b0.out_pc !== 32'h204) begin errs++; $display("FAIL second_pc: got %0h expected 204", b0.out_pc); end
    drive(1'b0, 32'h0, 32'h0);
    step();
    n++; if (b0.out_valid !== 1'b0) begin errs++; $display("FAIL refused_enq: got %0h expected 0", b0.out_valid); end
  endtask

  task automatic test_decode_misc();
    b0.out_ready = 1'b1;
    drive(1'b1, 32'h00000013, 32'h300);
    step();
    n++; if (b0.out_ctrl.reg_we !== 1'b0) begin errs++; $display("FAIL x0_reg_we: got %0h expected 0", b0.out_ctrl.reg_we); end
    n++; if (b0.out_illegal !== 1'b0) begin errs++; $display("FAIL nop_illegal: got %0h expected 0", b0.out_illegal); end
    drive(1'b1, 32'hFFFFFFFF, 32'h304);
    step();
    n++; if (b0.out_illegal !== 1'b1) begin errs++; $display("FAIL ones_illegal: got %0h expected 1", b0.out_illegal); end
    n++; if (b0.out_ctrl !== '0) begin errs++; $display("FAIL ones_ctrl: got %0h expected 0", b0.out_ctrl); end
    n++; if (b0.ill_count !== 4'd1) begin errs++; $display("FAIL ill_count_1: got %0h expected 1", b0.ill_count); end
    drive(1'b1, 32'h02109093, 32'h308);
    step();
    n++; if (b0.out_illegal !== 1'b1) begin errs++; $display("FAIL slli_b25: got %0h expected 1", b0.out_illegal); end
    n++; if (b0.ill_count !== 4'd2) begin errs++; $display("FAIL ill_count_2: got %0h expected 2", b0.ill_count); end
    drive(1'b1, 32'h4030D093, 32'h30C);
    step();
    n++; if (b0.out_illegal !== 1'b0) begin errs++; $display("FAIL srai_illegal: got %0h expected 0", b0.out_illegal); end
    n++; if (b0.out_ctrl.shift_op !== SH_SRA) begin errs++; $display("FAIL srai_shift: got %0h expected %0h", b0.out_ctrl.shift_op, SH_SRA); end
    n++; if (b0.out_ctrl.imm !== 32'd3) begin errs++; $display("FAIL srai_imm: got %0h expected 3", b0.out_ctrl.imm); end
    drive(1'b1, 32'hFE20FEE3, 32'h310);
    step();
    n++; if (b0.out_ctrl.imm !== 32'hFFFFFFFC) begin errs++; $display("FAIL bgeu_imm: got %0h expected fffffffc", b0.out_ctrl.imm); end
    n++; if (b0.out_ctrl.unsigned_flag !== 1'b1) begin errs++; $display("FAIL bgeu_uns: got %0h expected 1", b0.out_ctrl.unsigned_flag); end
    n++; if (b0.out_ctrl.branch_en !== 1'b1) begin errs++; $display("FAIL bgeu_branch: got %0h expected 1", b0.out_ctrl.branch_en); end
    n++; if (b0.out_ctrl.rs2 !== 5'd2) begin errs++; $display("FAIL bgeu_rs2: got %0h expected 2", b0.out_ctrl.rs2); end
    n++; if (b0.out_ctrl.alu_op !== ALU_GEU) begin errs++; $display("FAIL bgeu_op: got %0h expected %0h", b0.out_ctrl.alu_op, ALU_GEU); end
    drive(1'b1, 32'h0000C283, 32'h314);
    step();
    n++; if (b0.out_ctrl.unsigned_flag !== 1'b1) begin errs++; $display("FAIL lbu_uns: got %0h expected 1", b0.out_ctrl.unsigned_flag); end
    n++; if (b0.out_ctrl.mem_re !== 1'b1) begin errs++; $display("FAIL lbu_mem_re: got %0h expected 1", b0.out_ctrl.mem_re); end
    n++; if (b0.out_ctrl.rd !== 5'd5) begin errs++; $display("FAIL lbu_rd: got %0h expected 5", b0.out_ctrl.rd); end
    drive(1'b0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_m_ext();
    b0.out_ready = 1'b1;
    drive(1'b1, 32'h0220D033, 32'h400);
    b1.in_valid = 1'b1; b1.in_insn = 32'h0220D033; b1.in_pc = 32'h400;
    step();
    b1.in_valid = 1'b0;
    n++; if (b0.out_illegal !== 1'b0) begin errs++; $display("FAIL divu_illegal: got %0h expected 0", b0.out_illegal); end
    n++; if (b0.out_ctrl.div_op !== DIV_DIVU) begin errs++; $display("FAIL divu_op: got %0h expected %0h", b0.out_ctrl.div_op, DIV_DIVU); end
    n++; if (b0.out_ctrl.unsigned_flag !== 1'b1) begin errs++; $display("FAIL divu_uns: got %0h expected 1", b0.out_ctrl.unsigned_flag); end
    n++; if (b1.out_valid !== 1'b1) begin errs++; $display("FAIL nodiv_valid: got %0h expected 1", b1.out_valid); end
    n++; if (b1.out_illegal !== 1'b1) begin errs++; $display("FAIL nodiv_illegal: got %0h expected 1", b1.out_illegal); end
    n++; if (b1.out_ctrl !== '0) begin errs++; $display("FAIL nodiv_ctrl: got %0h expected 0", b1.out_ctrl); end
    n++; if (b1.ill_count !== 16'd1) begin errs++; $display("FAIL nodiv_count: got %0h expected 1", b1.ill_count); end
    drive(1'b1, 32'h022081B3, 32'h404);
    step();
    n++; if (b0.out_ctrl.mul_op !== MUL_MUL) begin errs++; $display("FAIL mul_op: got %0h expected %0h", b0.out_ctrl.mul_op, MUL_MUL); end
    n++; if (b0.out_ctrl.rd !== 5'd3) begin errs++; $display("FAIL mul_rd: got %0h expected 3", b0.out_ctrl.rd); end
    drive(1'b0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_flush();
    b0.out_ready = 1'b0;
    drive(1'b1, 32'h00100113, 32'h500);
    step();
    drive(1'b1, 32'h00100113, 32'h504);
    step();
    drive(1'b1, 32'hFFFFFFFF, 32'h508);
    b0.flush = 1'b1;
    step();
    b0.flush = 1'b0;
    n++; if (b0.out_valid !== 1'b0) begin errs++; $display("FAIL flush_full_valid: got %0h expected 0", b0.out_valid); end
    n++; if (b0.in_ready !== 1'b1) begin errs++; $display("FAIL flush_in_ready: got %0h expected 1", b0.in_ready); end
    n++; if (b0.ill_count !== 4'd2) begin errs++; $display("FAIL flush_full_count: got %0h expected 2", b0.ill_count); end
    drive(1'b1, 32'h00100113, 32'h50C);
    step();
    drive(1'b1, 32'hFFFFFFFF, 32'h510);
    b0.flush = 1'b1;
    step();
    b0.flush = 1'b0;
    n++; if (b0.out_valid !== 1'b0) begin errs++; $display("FAIL flush_one_valid: got %0h expected 0", b0.out_valid); end
    n++; if (b0.ill_count !== 4'd2) begin errs++; $display("FAIL flush_ill_count: got %0h expected 2", b0.ill_count); end
    drive(1'b1, 32'h00100113, 32'h600);
    step();
    drive(1'b0, 32'h0, 32'h0);
    n++; if (b0.out_pc !== 32'h600) begin errs++; $display("FAIL post_flush_pc: got %0h expected 600", b0.out_pc); end
    b0.out_ready = 1'b1;
    step();
    n++; if (b0.out_valid !== 1'b0) begin errs++; $display("FAIL post_flush_drain: got %0h expected 0", b0.out_valid); end
  endtask

  task automatic test_back_to_back();
    b0.out_ready = 1'b0;
    drive(1'b1, 32'h00100113, 32'h1000);
    step();
    b0.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h00100113, 32'(32'h1004 + 4 * i));
      n++; if (b0.out_pc !== 32'(32'h1000 + 4 * i)) begin errs++; $display("FAIL b2b_pc[%0d]: got %0h expected %0h", i, b0.out_pc, 32'h1000 + 4 * i); end
      n++; if (b0.in_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready[%0d]: got %0h expected 1", i, b0.in_ready); end
      step();
    end
    drive(1'b0, 32'h0, 32'h0);
    n++; if (b0.out_pc !== 32'h1028) begin errs++; $display("FAIL b2b_last_pc: got %0h expected 1028", b0.out_pc); end
    step();
    n++; if (b0.out_valid !== 1'b0) begin errs++; $display("FAIL b2b_count1: got %0h expected 0", b0.out_valid); end
  endtask

  task automatic test_saturation();
    reset = 1'b1;
    step();
    reset = 1'b0;
    b0.out_ready = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      drive(1'b1, 32'hFFFFFFFF, 32'(4 * k));
      step();
      n++; if (b0.ill_count !== 4'(k > 15 ? 15 : k)) begin errs++; $display("FAIL sat[%0d]: got %0h expected %0h", k, b0.ill_count, (k > 15 ? 15 : k)); end
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
    n++; if (b0.ill_count !== 4'hF) begin errs++; $display("FAIL sat_hold: got %0h expected f", b0.ill_count); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_full_drain();
    test_decode_misc();
    test_m_ext();
    test_flush();
    test_back_to_back();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n, errs);
    $finish;
  end
endmodule
